// File: rtl/magnitude_comparator.sv
// magnitude_comparator: registered WIDTH-bit A/B comparator with one-hot
// greater/equal/less flags, unsigned or two's-complement operands, and
// 7485-style cascade inputs so slices can be chained into wider comparators.
//
// Handshake: in_valid qualifies A, B, sgn and cas_* on a rising clk. There is
// no ready; every valid cycle is accepted. The result is on X/Y/Z one cycle
// later with out_valid high for exactly that cycle. Without in_valid, X/Y/Z
// keep their last value and out_valid drops.
module magnitude_comparator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sgn,
    input  logic             cas_gt,
    input  logic             cas_eq,
    input  logic             cas_lt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             X,
    output logic             Y,
    output logic             Z,
    output logic             out_valid
);

    logic             x_q, x_d;
    logic             y_q, y_d;
    logic             z_q, z_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] sign_mask;
    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;
    logic             core_gt;
    logic             core_lt;
    logic             casc_eq;

    // Signed compare: inverting both sign bits maps two's complement onto the
    // unsigned order, so one unsigned MSB-first compare serves both modes.
    always_comb begin
        sign_mask            = '0;
        sign_mask[WIDTH-1]   = sgn;
        a_k                  = A ^ sign_mask;
        b_k                  = B ^ sign_mask;
        core_gt              = 1'b0;
        core_lt              = 1'b0;
        // Scan LSB to MSB; a later (more significant) differing bit overrides,
        // so the first differing bit from the MSB side decides.
        for (int i = 0; i < WIDTH; i++) begin
            if (a_k[i] != b_k[i]) begin
                core_gt = a_k[i];
                core_lt = b_k[i];
            end
        end
        // Equal when cas_eq is set or no cascade flag is set; gt/lt take priority.
        casc_eq = !cas_gt && !cas_lt && (cas_eq || !(cas_gt || cas_lt));
    end

    // Next-state for the result flags: load on accept, otherwise hold.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            if (core_gt || core_lt) begin
                // Operands differ: cascade inputs do not matter.
                x_d = core_gt;
                y_d = 1'b0;
                z_d = core_lt;
            end else begin
                x_d = cas_gt;
                y_d = casc_eq;
                z_d = !cas_gt && cas_lt;
            end
        end
    end

    // Result registers; reset clears flags and drops any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            z_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign X         = x_q;
    assign Y         = y_q;
    assign Z         = z_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Directed bench for magnitude_comparator: reset behaviour, unsigned, signed,
// cascade, throughput/hold, WIDTH=1 signed corner and an exhaustive 4-bit sweep.
module tb_magnitude_comparator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       sgn = 1'b0;
    logic       cas_gt = 1'b0;
    logic       cas_eq = 1'b1;
    logic       cas_lt = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       x, y, z, out_valid;

    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       x1, y1, z1, out_valid1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    magnitude_comparator #(.WIDTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sgn(sgn),
        .cas_gt(cas_gt), .cas_eq(cas_eq), .cas_lt(cas_lt),
        .A(a), .B(b), .X(x), .Y(y), .Z(z), .out_valid(out_valid)
    );

    magnitude_comparator #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sgn(sgn),
        .cas_gt(cas_gt), .cas_eq(cas_eq), .cas_lt(cas_lt),
        .A(a1), .B(b1), .X(x1), .Y(y1), .Z(z1), .out_valid(out_valid1)
    );

    // Observed/expected are {out_valid, X, Y, Z}.
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
            $error("miscompare at %s", tag);
        end
    endtask

    // Present one accepted input; return #1 after the sampling edge.
    task automatic drive(input logic [3:0] ta, input logic [3:0] tb_, input logic s,
                         input logic g, input logic e, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        a = ta; b = tb_; sgn = s;
        cas_gt = g; cas_eq = e; cas_lt = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reference: signed/unsigned via native casts, then cascade on equality.
    function automatic logic [2:0] ref_cmp(input logic [3:0] ra, input logic [3:0] rb,
                                           input logic s, input logic g, input logic l);
        logic gt, lt;
        if (s) begin
            gt = $signed(ra) > $signed(rb);
            lt = $signed(ra) < $signed(rb);
        end else begin
            gt = ra > rb;
            lt = ra < rb;
        end
        if (gt) return 3'b100;
        if (lt) return 3'b001;
        if (g)  return 3'b100;
        if (l)  return 3'b001;
        return 3'b010;
    endfunction

    function automatic logic [3:0] obs4();
        return {out_valid, x, y, z};
    endfunction

    initial begin
        logic [2:0] exp3;
        logic       one_hot;

        // Reset state
        #1;
        check("reset_initial", obs4(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("after_release_idle", obs4(), 4'b0000);

        // Unsigned
        drive(4'h9, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        check("uns_9_3", obs4(), 4'b1100);
        drive(4'h3, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0);
        check("uns_3_D", obs4(), 4'b1001);
        drive(4'h5, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
        check("uns_5_5", obs4(), 4'b1010);
        idle();
        check("hold_after_5_5", obs4(), 4'b0010);
        idle();
        check("hold_second_idle", obs4(), 4'b0010);

        // Signed
        drive(4'hF, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("sgn_F_1", obs4(), 4'b1001);
        drive(4'h7, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0);
        check("sgn_7_8", obs4(), 4'b1100);
        drive(4'h8, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0);
        check("sgn_8_8", obs4(), 4'b1010);
        drive(4'h8, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0);
        check("uns_8_7", obs4(), 4'b1100);

        // Cascade
        drive(4'hA, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
        check("cas_gt", obs4(), 4'b1100);
        drive(4'hA, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
        check("cas_lt", obs4(), 4'b1001);
        drive(4'hA, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cas_none", obs4(), 4'b1010);
        drive(4'hA, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1);
        check("cas_multi_hot", obs4(), 4'b1100);
        drive(4'hA, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1);
        check("cas_lt_over_eq", obs4(), 4'b1001);
        drive(4'hB, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
        check("cas_ignored_B_A", obs4(), 4'b1100);
        drive(4'h2, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
        check("cas_ignored_2_6", obs4(), 4'b1001);

        // WIDTH=1 corner: 1 vs 0 unsigned is greater, signed (-1 vs 0) is less
        a1 = 1'b1; b1 = 1'b0;
        drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("w1_uns_1_0", {out_valid1, x1, y1, z1}, 4'b1100);
        drive(4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("w1_sgn_1_0", {out_valid1, x1, y1, z1}, 4'b1001);
        a1 = 1'b0; b1 = 1'b0;

        // Throughput and hold
        drive(4'h9, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_0", obs4(), 4'b1100);
        drive(4'h3, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_1", obs4(), 4'b1001);
        drive(4'h5, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_2", obs4(), 4'b1010);
        idle();
        check("b2b_hold", obs4(), 4'b0010);

        // Asynchronous reset mid-stream with X=1
        drive(4'hC, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_reset_x", obs4(), 4'b1100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", obs4(), 4'b0000);
        drive(4'h5, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
        check("in_reset_ignored", obs4(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_stays_0", obs4(), 4'b0000);
        drive(4'h1, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0);
        check("first_after_reset", obs4(), 4'b1001);

        // Exhaustive standalone sweep, back-to-back
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    drive(4'(i), 4'(j), 1'(s), 1'b0, 1'b1, 1'b0);
                    exp3 = ref_cmp(4'(i), 4'(j), 1'(s), 1'b0, 1'b0);
                    check($sformatf("sweep_s%0d_%0h_%0h", s, i, j), obs4(), {1'b1, exp3});
                    one_hot = ($countones({x, y, z}) == 1);
                    check($sformatf("onehot_s%0d_%0h_%0h", s, i, j), {3'b000, one_hot}, 4'b0001);
                end
            end
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/magnitude_comparator.md
Name: magnitude_comparator

Overview:
- Registered WIDTH-bit magnitude comparator: compares operands A and B, produces one-hot greater/equal/less flags.
- Supports unsigned or two's-complement comparison, plus 7485-style cascade inputs for chaining slices into wider comparators.
- Sits in datapath control logic wherever an ordering decision is needed. One-cycle latency, valid-qualified.

Parameters:
- WIDTH, 4, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and controls valid this cycle.
- sgn  input  1  1 = compare as two's complement, 0 = unsigned.
- cas_gt  input  1  cascade "greater" from less-significant slice; tie 0 when standalone.
- cas_eq  input  1  cascade "equal" from less-significant slice; tie 1 when standalone.
- cas_lt  input  1  cascade "less" from less-significant slice; tie 0 when standalone.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- X  output  1  registered A > B.
- Y  output  1  registered A == B.
- Z  output  1  registered A < B.
- out_valid  output  1  X/Y/Z updated from an accepted input this cycle.

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - X=0, Y=0, Z=0, out_valid=0 immediately.
  - Outputs remain so until the first accepted input after rst_n rises.
  - Reset mid-operation discards any in-flight result.
- Accept: on a rising clk with in_valid=1, sample A, B, sgn and cas_*.
  - Result appears on X/Y/Z at that edge's register output: one-cycle latency.
  - out_valid=1 for exactly that cycle.
- Back-to-back: in_valid high every cycle produces one result per cycle, in order. No stall, no backpressure.
- Idle: with in_valid=0, X/Y/Z hold their last value and out_valid=0 next cycle.
- Unsigned compare (sgn=0): A and B treated as 0..2^WIDTH-1.
- Signed compare (sgn=1): MSB is the sign bit.
  - If the MSBs differ, the operand with MSB=0 is greater.
  - Otherwise compare the remaining bits unsigned.
- Core comparison: combinational, MSB-first priority (first differing bit decides). Any equivalent structure (bitwise tree or subtractor) is acceptable if results match.
- Cascade, applied only when A == B bitwise:
  - cas_gt=1 -> X=1.
  - else cas_lt=1 -> Z=1.
  - else -> Y=1. This covers cas_eq=1, and also treats all-zero cascade inputs as equal.
  - Priority is cas_gt over cas_lt over cas_eq for illegal multi-hot cascade inputs.
- When A != B, cascade inputs are ignored.
- Invariant: after the first accepted input, exactly one of X/Y/Z is 1. Before that, all are 0.
- WIDTH=1: sgn=1 treats 1 as -1, so 1 < 0.

Test Plan:
- Reset: assert rst_n=0 mid-stream with X=1 -> X/Y/Z/out_valid go 0 without a clock edge; they stay 0 until the first in_valid after release.
- Unsigned, sgn=0, cascade 0/1/0:
  - A=4'h9, B=4'h3 -> next cycle X=1, Y=0, Z=0, out_valid=1.
  - A=4'h3, B=4'hD -> Z=1.
  - A=4'h5, B=4'h5 -> Y=1.
- Signed, sgn=1:
  - A=4'hF (-1), B=4'h1 -> Z=1.
  - A=4'h7, B=4'h8 (-8) -> X=1.
  - A=4'h8, B=4'h8 -> Y=1.
- Cascade, A=B=4'hA:
  - cas 1/0/0 -> X=1.
  - cas 0/0/1 -> Z=1.
  - cas 0/0/0 -> Y=1.
  - A=4'hB, B=4'hA with cas_lt=1 -> X=1 (cascade ignored).
- Throughput/hold: three consecutive valid pairs (9,3), (3,D), (5,5) -> X, Z, Y on consecutive cycles with out_valid high. Then in_valid=0 -> Y holds 1, out_valid=0.
- Exhaustive: all 256 A/B pairs × sgn {0,1} with standalone cascade -> match reference model; exactly one flag high per result.
